// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter: shares the single cart memory word port between the CHR,
// PRG and AUX address producers. Each port holds one pending request. The
// fixed priority is CHR > PRG > AUX. An access uses a req/ack handshake with a
// saturating timeout. Read data is returned per port with a one-cycle done pulse.
// Optional feature: define CART_MEM_ARB_AGING_EN for starvation aging of PRG/AUX.
module cart_mem_arbiter #(
   parameter logic [7:0] TIMEOUT = 8'd255,
   parameter logic [2:0] AGE_MAX = 3'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chr_req,
   input  logic        chr_we,
   input  logic [21:0] chr_addr,
   input  logic [7:0]  chr_wdata,
   input  logic        prg_req,
   input  logic        prg_we,
   input  logic [21:0] prg_addr,
   input  logic [7:0]  prg_wdata,
   input  logic        aux_req,
   input  logic        aux_we,
   input  logic [21:0] aux_addr,
   input  logic [7:0]  aux_wdata,
   output logic        chr_busy,
   output logic        prg_busy,
   output logic        aux_busy,
   output logic        chr_done,
   output logic        prg_done,
   output logic        aux_done,
   output logic [7:0]  chr_rdata,
   output logic [7:0]  prg_rdata,
   output logic [7:0]  aux_rdata,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [21:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata
);

   localparam logic [1:0] P_CHR = 2'd0;
   localparam logic [1:0] P_PRG = 2'd1;
   localparam logic [1:0] P_AUX = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
   state_t state, state_nx;

   logic [2:0]  req_v, we_v;
   logic [21:0] addr_v  [3];
   logic [7:0]  wdata_v [3];
   logic [2:0]  pend, we_q;
   logic [21:0] addr_q  [3];
   logic [7:0]  wdata_q [3];
   logic [1:0]  sel, win;
   logic [7:0]  wait_cnt, rbuf;
   logic        abort, tmo_hit, finish;
   logic [2:0]  done_q;
   logic [7:0]  rdata_q [3];

   assign req_v      = {aux_req, prg_req, chr_req};
   assign we_v       = {aux_we, prg_we, chr_we};
   assign addr_v[0]  = chr_addr;
   assign addr_v[1]  = prg_addr;
   assign addr_v[2]  = aux_addr;
   assign wdata_v[0] = chr_wdata;
   assign wdata_v[1] = prg_wdata;
   assign wdata_v[2] = aux_wdata;

   // The counter reaching TIMEOUT on this edge; an ack in the same cycle still wins.
   assign tmo_hit = ({1'b0, wait_cnt} + 9'd1) >= {1'b0, TIMEOUT};
   assign finish  = (state == S_WAIT) && (mem_ack || tmo_hit);

`ifdef CART_MEM_ARB_AGING_EN
   logic [2:0] age_prg, age_aux;

   // Count arbitrations lost by a waiting PRG/AUX port; its own grant restarts the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         age_prg <= '0;
         age_aux <= '0;
      end else if (state == S_IDLE && |pend) begin
         if (sel == P_PRG)
            age_prg <= '0;
         else if (pend[1] && age_prg != 3'd7)
            age_prg <= age_prg + 3'd1;
         if (sel == P_AUX)
            age_aux <= '0;
         else if (pend[2] && age_aux != 3'd7)
            age_aux <= age_aux + 3'd1;
      end
   end
`else
   logic unused_age_max;
   assign unused_age_max = ^AGE_MAX;
`endif

   // Winner select: fixed priority, overridden by a promoted (aged) PRG, then AUX.
   always_comb begin
      if (pend[0])
         sel = P_CHR;
      else if (pend[1])
         sel = P_PRG;
      else
         sel = P_AUX;
`ifdef CART_MEM_ARB_AGING_EN
      if (pend[1] && age_prg >= AGE_MAX)
         sel = P_PRG;
      else if (pend[2] && age_aux >= AGE_MAX)
         sel = P_AUX;
`endif
   end

   // Pending slots: capture a strobe only when free; release when the access finishes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend <= '0;
         we_q <= '0;
         for (int i = 0; i < 3; i++) begin
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (req_v[i] && !pend[i]) begin
               pend[i]    <= 1'b1;
               we_q[i]    <= we_v[i];
               addr_q[i]  <= addr_v[i];
               wdata_q[i] <= wdata_v[i];
            end
         end
         if (finish)
            pend[win] <= 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // FSM next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (|pend) state_nx = S_ISSUE;
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT:  if (mem_ack || tmo_hit) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Memory port, timeout counter and per-port completion registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win       <= P_CHR;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wait_cnt  <= '0;
         abort     <= 1'b0;
         rbuf      <= '0;
         done_q    <= '0;
         err       <= 1'b0;
         for (int i = 0; i < 3; i++)
            rdata_q[i] <= '0;
      end else begin
         done_q <= '0;
         err    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (|pend) begin
                  win       <= sel;
                  mem_req   <= 1'b1;
                  mem_we    <= we_q[sel];
                  mem_addr  <= addr_q[sel];
                  mem_wdata <= wdata_q[sel];
                  abort     <= 1'b0;
               end
            end
            S_ISSUE: wait_cnt <= '0;
            S_WAIT: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (!mem_we)
                     rbuf <= mem_rdata;
               end else if (tmo_hit) begin
                  mem_req <= 1'b0;
                  abort   <= 1'b1;
               end else if (wait_cnt != 8'hFF) begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_DONE: begin
               done_q[win] <= 1'b1;
               err         <= abort;
               if (abort)
                  rdata_q[win] <= 8'hFF;
               else if (!mem_we)
                  rdata_q[win] <= rbuf;
            end
            default: ;
         endcase
      end
   end

   assign chr_busy  = pend[0];
   assign prg_busy  = pend[1];
   assign aux_busy  = pend[2];
   assign chr_done  = done_q[0];
   assign prg_done  = done_q[1];
   assign aux_done  = done_q[2];
   assign chr_rdata = rdata_q[0];
   assign prg_rdata = rdata_q[1];
   assign aux_rdata = rdata_q[2];

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Bench for cart_mem_arbiter: scoreboard of expected completions plus a
// simple memory responder with a programmable ack latency.
module tb_cart_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        chr_req, chr_we, prg_req, prg_we, aux_req, aux_we;
   logic [21:0] chr_addr, prg_addr, aux_addr;
   logic [7:0]  chr_wdata, prg_wdata, aux_wdata;
   logic        chr_busy, prg_busy, aux_busy, chr_done, prg_done, aux_done;
   logic [7:0]  chr_rdata, prg_rdata, aux_rdata;
   logic        err, mem_req, mem_we, mem_ack;
   logic [21:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   cart_mem_arbiter #(.TIMEOUT(8'd8), .AGE_MAX(3'd4)) dut (
      .clk(clk), .reset(reset),
      .chr_req(chr_req), .chr_we(chr_we), .chr_addr(chr_addr), .chr_wdata(chr_wdata),
      .prg_req(prg_req), .prg_we(prg_we), .prg_addr(prg_addr), .prg_wdata(prg_wdata),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .chr_busy(chr_busy), .prg_busy(prg_busy), .aux_busy(aux_busy),
      .chr_done(chr_done), .prg_done(prg_done), .aux_done(aux_done),
      .chr_rdata(chr_rdata), .prg_rdata(prg_rdata), .aux_rdata(aux_rdata),
      .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          port;
      logic [21:0] addr;
      logic        we;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [21:0] iss_q[$];
   logic [7:0]  exp_rd [3];
   int          n_checks = 0, n_errors = 0;
   int          cyc = 0, ack_lat = 1, k = 0, last_len = 0, n_req = 0, n_done_tot = 0;
   int          n_done [3];
   bit          ack_force = 1'b0, sb_en = 1'b1, stab_err = 1'b0;
   logic [21:0] iss_addr = '0;
   logic        iss_we = 1'b0;
   logic [7:0]  iss_wdata = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [21:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h78;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Memory responder: ack in WAIT cycle ack_lat (0 = never), log each issued access.
   always @(negedge clk) begin
      if (mem_req) begin
         k = k + 1;
         if (k == 1) begin
            iss_addr  = mem_addr;
            iss_we    = mem_we;
            iss_wdata = mem_wdata;
            stab_err  = 1'b0;
            n_req++;
            iss_q.push_back(mem_addr);
         end else if (mem_addr !== iss_addr || mem_we !== iss_we || mem_wdata !== iss_wdata) begin
            stab_err = 1'b1;
         end
         mem_ack   = (ack_lat != 0) && (k == ack_lat + 1);
         mem_rdata = mem_ack ? model(mem_addr) : 8'h00;
         last_len  = k;
      end else begin
         k         = 0;
         mem_ack   = ack_force;
         mem_rdata = 8'h00;
      end
   end

   // Completion monitor: pop the scoreboard on every done pulse.
   logic [2:0] dv;
   int         gp;
   exp_t       me;
   logic [7:0] prd;
   always @(negedge clk) begin
      dv = {aux_done, prg_done, chr_done};
      if (dv != 3'b000) n_done_tot++;
      for (int i = 0; i < 3; i++) if (dv[i]) n_done[i]++;
      if (err && dv == 3'b000) check_eq("err_without_done", err, 0);
      if (dv != 3'b000 && sb_en) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_done", dv, 0);
         end else begin
            me = sb.pop_front();
            gp = (dv == 3'b001) ? 0 : (dv == 3'b010) ? 1 : (dv == 3'b100) ? 2 : 3;
            check_eq("done_port", gp, me.port);
            check_eq("mem_addr", iss_addr, me.addr);
            check_eq("mem_we", iss_we, me.we);
            if (me.we) check_eq("mem_wdata", iss_wdata, me.wdata);
            prd = (me.port == 0) ? chr_rdata : (me.port == 1) ? prg_rdata : aux_rdata;
            check_eq("rdata", prd, me.rdata);
            check_eq("err", err, me.err);
            check_eq("addr_stable", stab_err, 0);
         end
      end
   end

   task automatic set_req(input int p, input logic we, input logic [21:0] a,
                          input logic [7:0] d, input bit expect_it);
      exp_t e;
      case (p)
         0: begin chr_req = 1'b1; chr_we = we; chr_addr = a; chr_wdata = d; end
         1: begin prg_req = 1'b1; prg_we = we; prg_addr = a; prg_wdata = d; end
         default: begin aux_req = 1'b1; aux_we = we; aux_addr = a; aux_wdata = d; end
      endcase
      if (expect_it) begin
         e.port  = p;
         e.addr  = a;
         e.we    = we;
         e.wdata = d;
         e.err   = (ack_lat == 0) || (ack_lat > 8);
         if (e.err) e.rdata = 8'hFF;
         else if (we) e.rdata = exp_rd[p];
         else e.rdata = model(a);
         exp_rd[p] = e.rdata;
         sb.push_back(e);
      end
   endtask

   task automatic step();
      @(negedge clk);
      chr_req = 1'b0;
      prg_req = 1'b0;
      aux_req = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !mem_req && !chr_busy && !prg_busy && !aux_busy &&
             !chr_done && !prg_done && !aux_done) break;
      end
      if (i >= budget) check_eq("idle_timeout", i, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int c0, t_req, t_done, nr0, nd0, aux_idx, i;

   initial begin
      reset = 1'b1;
      chr_req = 0; chr_we = 0; chr_addr = '0; chr_wdata = '0;
      prg_req = 0; prg_we = 0; prg_addr = '0; prg_wdata = '0;
      aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
      for (int j = 0; j < 3; j++) begin exp_rd[j] = 8'h00; n_done[j] = 0; end
      repeat (3) @(negedge clk);
      check_eq("rst_busy", {chr_busy, prg_busy, aux_busy}, 0);
      check_eq("rst_done", {chr_done, prg_done, aux_done}, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_mem_req", mem_req, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
      check_eq("rst_rdata", {chr_rdata, prg_rdata, aux_rdata}, 0);
      reset = 1'b0;
      @(negedge clk);

      // Single CHR read, ack in the third WAIT cycle
      ack_lat = 3;
      set_req(0, 1'b0, 22'h20_0123, 8'h00, 1'b1);
      step();
      check_eq("chr_busy_set", chr_busy, 1);
      wait_idle(50);
      check_eq("chr_rdata_5a", chr_rdata, 8'h5A);
      check_eq("chr_busy_clear", chr_busy, 0);
      check_eq("chr_done_count", n_done[0], 1);

      // Minimum latency: PRG write with ack in the first WAIT cycle
      ack_lat = 1;
      c0 = cyc; t_req = -1; t_done = -1;
      set_req(1, 1'b1, 22'h00_0777, 8'h3C, 1'b1);
      step();
      for (int j = 0; j < 20; j++) begin
         if (mem_req && t_req < 0) t_req = cyc - c0;
         if (prg_done) begin t_done = cyc - c0; break; end
         @(negedge clk);
      end
      check_eq("lat_strobe_to_req", t_req, 2);
      check_eq("lat_strobe_to_done", t_done, 5);
      wait_idle(50);

      // Simultaneous strobes on all three ports
      ack_lat = 2;
      nr0 = n_req;
      set_req(0, 1'b0, 22'h00_0100, 8'h00, 1'b1);
      set_req(1, 1'b0, 22'h00_0200, 8'h00, 1'b1);
      set_req(2, 1'b0, 22'h3F_0AB0, 8'h00, 1'b1);
      step();
      wait_idle(100);
      check_eq("simul_req_count", n_req - nr0, 3);

      // AUX write leaves aux_rdata untouched
      ack_lat = 1;
      set_req(2, 1'b1, 22'h3F_0010, 8'hC3, 1'b1);
      step();
      wait_idle(50);

      // PRG read never acked: abort after 8 WAIT cycles
      ack_lat = 0;
      set_req(1, 1'b0, 22'h00_4444, 8'h00, 1'b1);
      step();
      wait_idle(60);
      check_eq("timeout_req_cycles", last_len, 9);
      check_eq("timeout_rdata_ff", prg_rdata, 8'hFF);

      // Ack in the same cycle the counter reaches TIMEOUT is a normal completion
      ack_lat = 8;
      set_req(1, 1'b0, 22'h00_1234, 8'h00, 1'b1);
      step();
      wait_idle(60);
      check_eq("edge_ack_req_cycles", last_len, 9);

      // Duplicate strobe while busy is dropped
      ack_lat = 2;
      nr0 = n_req; nd0 = n_done[1];
      set_req(1, 1'b0, 22'h00_8000, 8'h00, 1'b1);
      step();
      set_req(1, 1'b0, 22'h00_9000, 8'h00, 1'b0);
      step();
      wait_idle(60);
      check_eq("dup_req_count", n_req - nr0, 1);
      check_eq("dup_done_count", n_done[1] - nd0, 1);

      // Strobe in the same cycle as that port's done is accepted
      ack_lat = 1;
      nr0 = n_req;
      set_req(1, 1'b0, 22'h00_0A0A, 8'h00, 1'b1);
      step();
      for (i = 0; i < 30; i++) begin
         if (prg_done) break;
         @(negedge clk);
      end
      check_eq("done_seen", i < 30, 1);
      set_req(1, 1'b0, 22'h00_0B0B, 8'h00, 1'b1);
      step();
      wait_idle(60);
      check_eq("done_cycle_req_count", n_req - nr0, 2);

      // Stray ack while idle is ignored
      nr0 = n_req; nd0 = n_done_tot;
      ack_force = 1'b1;
      repeat (3) @(negedge clk);
      ack_force = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("stray_ack_req", n_req - nr0, 0);
      check_eq("stray_ack_done", n_done_tot - nd0, 0);

      // Reset asserted mid-WAIT
      ack_lat = 0;
      set_req(0, 1'b0, 22'h11_2233, 8'h00, 1'b0);
      set_req(1, 1'b0, 22'h00_5555, 8'h00, 1'b0);
      step();
      repeat (4) @(negedge clk);
      check_eq("pre_rst_mem_req", mem_req, 1);
      #2 reset = 1'b1;
      #1;
      check_eq("async_rst_mem_req", mem_req, 0);
      check_eq("async_rst_busy", {chr_busy, prg_busy, aux_busy}, 0);
      check_eq("async_rst_done", {chr_done, prg_done, aux_done}, 0);
      check_eq("async_rst_rdata", chr_rdata, 8'h00);
      for (int j = 0; j < 3; j++) exp_rd[j] = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      nr0 = n_req; nd0 = n_done_tot;
      repeat (20) @(negedge clk);
      check_eq("post_rst_req", n_req - nr0, 0);
      check_eq("post_rst_done", n_done_tot - nd0, 0);
      check_eq("post_rst_busy", {chr_busy, prg_busy, aux_busy}, 0);

      // AUX pending under saturated CHR traffic
      sb_en = 1'b0;
      ack_lat = 1;
      iss_q.delete();
      set_req(2, 1'b0, 22'h03_0000, 8'h00, 1'b0);
      set_req(0, 1'b0, 22'h01_0000, 8'h00, 1'b0);
      step();
      for (int j = 0; j < 60; j++) begin
         chr_req = 1'b1;
         @(negedge clk);
      end
      chr_req = 1'b0;
      wait_idle(100);
      aux_idx = -1;
      for (int j = 0; j < iss_q.size(); j++)
         if (iss_q[j] == 22'h03_0000 && aux_idx < 0) aux_idx = j;
`ifdef CART_MEM_ARB_AGING_EN
      check_eq("aux_after_4_chr", aux_idx, 4);
`else
      check_eq("aux_starved_last", aux_idx, iss_q.size() - 1);
      check_eq("chr_saturated_grants", iss_q.size() > 8, 1);
`endif
      sb_en = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cart_mem_arbiter.md
# cart_mem_arbiter

Cartridge memory arbiter that shares the single external cart memory port (SDRAM/BRAM word port) between the three address producers around the mapper: PPU CHR fetches, CPU PRG accesses, and an auxiliary loader/savestate port. It sits between the active mapper's translated addresses (`prg_aout`, `chr_aout`) and the memory controller. It latches one pending request per port, grants by fixed priority with optional starvation aging, runs a req/ack handshake with timeout, and returns read data per port with a done pulse.

## Interface
- `TIMEOUT`, 8'd255: cycles without `mem_ack` before a granted access is aborted (1..255).
- `AGE_MAX`, 3'd4: lower-priority grants lost by a waiting port before it is promoted to top priority.
- `clk` in 1: system clock. One clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `chr_req` in 1: single-cycle request strobe, CHR port. `chr_we` in 1; `chr_addr` in 22; `chr_wdata` in 8.
- `prg_req` in 1: request strobe, PRG port. `prg_we` in 1; `prg_addr` in 22; `prg_wdata` in 8.
- `aux_req` in 1: request strobe, aux port. `aux_we` in 1; `aux_addr` in 22; `aux_wdata` in 8.
- `chr_busy`, `prg_busy`, `aux_busy` out 1: port has a pending or in-flight request.
- `chr_done`, `prg_done`, `aux_done` out 1: one-cycle completion pulse.
- `chr_rdata`, `prg_rdata`, `aux_rdata` out 8: registered read data, held until the next completion on that port.
- `err` out 1: one-cycle pulse coincident with a done that ended in timeout.
- `mem_req` out 1: request to memory, held until ack or abort. `mem_we` out 1; `mem_addr` out 22; `mem_wdata` out 8.
- `mem_ack` in 1: memory accepted/completed the access. `mem_rdata` in 8: valid in the `mem_ack` cycle.

## Operation
- Per-port pending register: a strobe while `busy`=0 captures we/addr/wdata and sets `busy`. A strobe while `busy`=1 is dropped and the captured fields are unchanged. A strobe in the same cycle as that port's `done` is accepted.
- FSM states:
  - IDLE: if any pending, select the winner and load `mem_*`. Go to ISSUE.
  - ISSUE: `mem_req`=1, timeout counter cleared. Next cycle go to WAIT.
  - WAIT: hold `mem_req`. On `mem_ack`, capture `mem_rdata` (reads only) and go to DONE. When the counter reaches `TIMEOUT`, go to DONE with the abort flag set.
  - DONE: `mem_req`=0. Pulse the winner's `done`. Clear its `busy`. Go to IDLE.
- Priority: CHR > PRG > AUX.
- Write completion: `rdata` is unchanged.
- Abort completion: `rdata` is forced to 8'hFF and `err` pulses.
- `mem_ack` outside WAIT is ignored.
- A `mem_ack` in the same cycle the counter reaches `TIMEOUT` counts as an ack (no abort).
- Timeout counter: 8 bits, saturating, never wraps.

## Timing
- Reset values: all `busy`, `done`, `err`, `mem_req`, `mem_we` = 0. All `rdata` = 8'h00. `mem_addr` = 0, `mem_wdata` = 0. FSM in IDLE. Pending and age state cleared.
- Reset asserted mid-access drops `mem_req` immediately (asynchronously). No `done` is issued for the lost request.
- Latency from strobe on an idle arbiter: pending at edge 1, IDLE→ISSUE at edge 2 with `mem_req` high, so `mem_req` rises 2 cycles after the strobe.
- With `mem_ack` in the first WAIT cycle, `done` pulses 2 cycles after `mem_ack`.
- Minimum strobe-to-done: 5 cycles.
- Back-to-back throughput: one access per 4 cycles plus memory latency.
- `mem_addr`, `mem_we` and `mem_wdata` are stable for the whole time `mem_req` is high.

## Configuration
- `CART_MEM_ARB_AGING_EN` defined:
  - Each pending PRG/AUX port counts lost arbitrations in a 3-bit counter.
  - At `AGE_MAX` that port wins the next arbitration over all others; ties among promoted ports go to PRG first.
  - A port's counter clears on its grant.
- Undefined: pure fixed priority. AUX can starve under continuous CHR/PRG traffic. No age counters are synthesized.

## Test plan
- Single CHR read: `chr_req` with addr 22'h20_0123; ack after 3 WAIT cycles with `mem_rdata`=8'h5A -> `mem_addr`=22'h20_0123, `chr_done` once, `chr_rdata`=8'h5A, `chr_busy` low after done.
- Simultaneous strobes on all three ports -> grant order CHR, PRG, AUX. Exactly three `mem_req` assertions. Each done pulses once in that order.
- Timeout: PRG read with `mem_ack` never asserted, `TIMEOUT`=8 -> `mem_req` drops after 8 WAIT cycles, `prg_done` and `err` pulse together, `prg_rdata`=8'hFF.
- Duplicate strobe: `prg_req` addr 22'h00_8000, then `prg_req` addr 22'h00_9000 while busy -> only 22'h00_8000 is issued, one `prg_done`.
- Reset mid-WAIT: assert `reset` while `mem_req`=1 -> `mem_req`, all `busy` and `done` go 0 without a clock edge. After release, idle with no spurious done.
- With `CART_MEM_ARB_AGING_EN` defined and `AGE_MAX`=4: AUX pending under continuous CHR strobes -> AUX granted after exactly 4 CHR grants. Without the macro -> AUX is never granted while CHR stays saturated.
